drum_acc: RTL and testbench



---
 rtl/drum_pkg.sv | 16 +
 rtl/drum_acc_add.sv | 25 ++
 rtl/drum_acc.sv | 93 +++++++++
 tb/tb_drum_acc.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/drum_pkg.sv
// Shared constants and types for the DRUM approximate multiplier datapath and
// its frame accumulator.
package drum_pkg;

  localparam int K_IN   = 4;
  localparam int N_IN   = 16;
  localparam int M_IN   = 16;
  localparam int PROD_W = N_IN + M_IN;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HOLD
  } acc_state_e;

endpackage

// File: rtl/drum_acc_add.sv
// Combinational unsigned ACC_W-bit adder with carry out.
// When DRUM_ACC_SAT_EN is defined, a carry clamps the sum to all ones.
module drum_acc_add #(
  parameter int ACC_W  = 40,
  parameter int PROD_W = 32
) (
  input  logic [ACC_W-1:0]  a,
  input  logic [PROD_W-1:0] b,
  output logic [ACC_W-1:0]  sum,
  output logic              carry
);

  logic [ACC_W:0] full;

  assign full  = {1'b0, a} + {{(ACC_W + 1 - PROD_W){1'b0}}, b};
  assign carry = full[ACC_W];

`ifdef DRUM_ACC_SAT_EN
  // A clamped sum stays clamped: any further nonzero beat carries again.
  assign sum = carry ? {ACC_W{1'b1}} : full[ACC_W-1:0];
`else
  assign sum = full[ACC_W-1:0];
`endif

endmodule

// File: rtl/drum_acc.sv
// Frame accumulator for DRUM approximate products (accumulate half of a MAC).
// Optional clamp-on-overflow is enabled by defining DRUM_ACC_SAT_EN.
module drum_acc #(
  parameter  int PROD_W  = drum_pkg::PROD_W,
  parameter  int ACC_W   = 40,
  parameter  int MAX_LEN = 256,
  localparam int CNT_W   = $clog2(MAX_LEN) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prod_valid,
  output logic              prod_ready,
  input  logic [PROD_W-1:0] prod_data,
  input  logic              prod_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_data,
  output logic [CNT_W-1:0]  out_cnt,
  output logic              out_ovf
);
  import drum_pkg::*;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LEN);

  acc_state_e       state;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] add_sum;
  logic [CNT_W-1:0] cnt;
  logic             ovf;
  logic             add_carry;
  logic             xfer;
  logic             close;

  assign prod_ready = (state != HOLD);
  assign xfer       = prod_valid && prod_ready;

  drum_acc_add #(
    .ACC_W  (ACC_W),
    .PROD_W (PROD_W)
  ) u_add (
    .a     (acc),
    .b     (prod_data),
    .sum   (add_sum),
    .carry (add_carry)
  );

  // The first beat sets the count to 1; later beats close when they reach MAX_LEN.
  assign close = prod_last ||
                 ((state == IDLE) ? (MAX_LEN == 1) : ((cnt + 1'b1) == MAX_CNT));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (xfer) begin
          acc       <= ACC_W'(prod_data);
          cnt       <= CNT_W'(1);
          ovf       <= 1'b0;
          state     <= close ? HOLD : ACCUM;
          out_valid <= close;
        end
        ACCUM: if (xfer) begin
          acc       <= add_sum;
          cnt       <= cnt + 1'b1;
          ovf       <= ovf | add_carry;
          state     <= close ? HOLD : ACCUM;
          out_valid <= close;
        end
        HOLD: if (out_ready) begin
          acc       <= '0;
          cnt       <= '0;
          ovf       <= 1'b0;
          state     <= IDLE;
          out_valid <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign out_data = acc;
  assign out_cnt  = cnt;
  assign out_ovf  = ovf;

endmodule

// File: tb/tb_drum_acc.sv
// Bench for drum_acc: directed table, hand-written corner sequences and a
// randomized run against a frame-level reference model.
module tb_drum_acc;

  localparam int PROD_W  = 32;
  localparam int ACC_W   = 33;
  localparam int MAX_LEN = 256;
  localparam int CNT_W   = $clog2(MAX_LEN) + 1;
  localparam longint unsigned LIM = 64'd1 << ACC_W;
`ifdef DRUM_ACC_SAT_EN
  localparam logic [63:0] EXP_BIG = 64'h1_FFFF_FFFF;
`else
  localparam logic [63:0] EXP_BIG = 64'h0_FFFF_FFFD;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              prod_valid;
  logic              prod_ready;
  logic [PROD_W-1:0] prod_data;
  logic              prod_last;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_data;
  logic [CNT_W-1:0]  out_cnt;
  logic              out_ovf;

  drum_acc #(
    .PROD_W  (PROD_W),
    .ACC_W   (ACC_W),
    .MAX_LEN (MAX_LEN)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .prod_valid (prod_valid),
    .prod_ready (prod_ready),
    .prod_data  (prod_data),
    .prod_last  (prod_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_cnt    (out_cnt),
    .out_ovf    (out_ovf)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Model: a frame is its true (unbounded) sum and beat count.
  typedef struct {
    longint unsigned sum;
    int              cnt;
  } frame_t;

  frame_t          exp_q[$];
  longint unsigned cur_sum = 0;
  int              cur_cnt = 0;

  typedef struct {
    logic [31:0] data;
    bit          last;
    bit          chk;
    logic [63:0] exp_data;
    int          exp_cnt;
    bit          exp_ovf;
    int          exp_stall;
  } vec_t;

  vec_t vt[11];

  function automatic logic [63:0] model_data(input longint unsigned s);
`ifdef DRUM_ACC_SAT_EN
    return (s >= LIM) ? (LIM - 1) : s;
`else
    return s % LIM;
`endif
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock: feed the handshakes seen before the edge to the model, then
  // check the outputs at the following falling edge.
  task automatic tick(output bit xfer);
    frame_t           f;
    bit               held;
    logic [ACC_W-1:0] prev_data;
    logic [CNT_W-1:0] prev_cnt;
    xfer      = 1'b0;
    held      = out_valid && !out_ready && !rst;
    prev_data = out_data;
    prev_cnt  = out_cnt;
    if (rst) begin
      cur_sum = 0;
      cur_cnt = 0;
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL release: out_valid=1 with no frame expected");
        end else begin
          f = exp_q.pop_front();
          check("out_data", out_data, model_data(f.sum));
          check("out_cnt", out_cnt, f.cnt);
          check("out_ovf", out_ovf, f.sum >= LIM);
        end
      end
      if (prod_valid && prod_ready) begin
        xfer = 1'b1;
        cur_sum += prod_data;
        cur_cnt++;
        if (prod_last || cur_cnt == MAX_LEN) begin
          exp_q.push_back('{cur_sum, cur_cnt});
          cur_sum = 0;
          cur_cnt = 0;
        end
      end
    end
    @(negedge clk);
    check("out_valid", out_valid, exp_q.size() != 0);
    check("prod_ready", prod_ready, exp_q.size() == 0);
    if (held) begin
      check("hold_data", out_data, prev_data);
      check("hold_cnt", out_cnt, prev_cnt);
    end
  endtask

  task automatic send(input logic [31:0] d, input bit l, output int stall);
    bit x;
    prod_valid = 1'b1;
    prod_data  = d;
    prod_last  = l;
    stall      = 0;
    tick(x);
    while (!x && stall < 8) begin
      stall++;
      tick(x);
    end
    if (!x) begin
      n_chk++;
      n_fail++;
      $display("FAIL send: beat 0x%0h not accepted within 8 cycles", d);
    end
    prod_valid = 1'b0;
  endtask

  initial begin
    int st;
    bit x;
    rst        = 1'b1;
    prod_valid = 1'b0;
    prod_data  = '0;
    prod_last  = 1'b0;
    out_ready  = 1'b0;

    vt[0]  = '{32'd15,         1'b0, 1'b0, 64'd0,   0, 1'b0, 0};
    vt[1]  = '{32'd100,        1'b0, 1'b0, 64'd0,   0, 1'b0, 0};
    vt[2]  = '{32'd7,          1'b1, 1'b1, 64'd122, 3, 1'b0, 0};
    vt[3]  = '{32'd0,          1'b1, 1'b1, 64'd0,   1, 1'b0, 1};
    vt[4]  = '{32'hFFFF_FFFF,  1'b0, 1'b0, 64'd0,   0, 1'b0, 1};
    vt[5]  = '{32'hFFFF_FFFF,  1'b0, 1'b0, 64'd0,   0, 1'b0, 0};
    vt[6]  = '{32'hFFFF_FFFF,  1'b1, 1'b1, EXP_BIG, 3, 1'b1, 0};
    vt[7]  = '{32'd1,          1'b0, 1'b0, 64'd0,   0, 1'b0, 1};
    vt[8]  = '{32'd2,          1'b0, 1'b0, 64'd0,   0, 1'b0, 0};
    vt[9]  = '{32'd3,          1'b0, 1'b0, 64'd0,   0, 1'b0, 0};
    vt[10] = '{32'd4,          1'b1, 1'b1, 64'd10,  4, 1'b0, 0};

    @(negedge clk);
    tick(x);
    tick(x);
    rst = 1'b0;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_cnt", out_cnt, 0);
    check("rst_out_ovf", out_ovf, 0);
    check("rst_prod_ready", prod_ready, 1);

    // Back-to-back beats: exactly one bubble after each closing beat.
    out_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      send(vt[i].data, vt[i].last, st);
      check($sformatf("stall[%0d]", i), st, vt[i].exp_stall);
      if (vt[i].chk) begin
        check($sformatf("vec_valid[%0d]", i), out_valid, 1);
        check($sformatf("vec_data[%0d]", i), out_data, vt[i].exp_data);
        check($sformatf("vec_cnt[%0d]", i), out_cnt, vt[i].exp_cnt);
        check($sformatf("vec_ovf[%0d]", i), out_ovf, vt[i].exp_ovf);
      end
    end
    tick(x);

    // Consumer stalls 5 cycles while a beat is offered.
    out_ready = 1'b0;
    send(32'd10, 1'b0, st);
    send(32'd20, 1'b1, st);
    prod_valid = 1'b1;
    prod_data  = 32'd99;
    prod_last  = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check("stall_data", out_data, 30);
      check("stall_ready", prod_ready, 0);
      tick(x);
      check("stall_xfer", x, 0);
    end
    prod_valid = 1'b0;
    out_ready  = 1'b1;
    tick(x);
    check("release_valid", out_valid, 0);

    // Forced close at MAX_LEN, then the next beat opens a fresh frame.
    for (int i = 0; i < MAX_LEN; i++) send(32'd1, 1'b0, st);
    check("force_valid", out_valid, 1);
    check("force_data", out_data, 256);
    check("force_cnt", out_cnt, 256);
    send(32'd1, 1'b1, st);
    check("after_force_cnt", out_cnt, 1);
    check("after_force_data", out_data, 1);

    // prod_last on the MAX_LEN-th beat closes a single frame.
    for (int i = 0; i < MAX_LEN; i++) send(32'd2, (i == MAX_LEN - 1), st);
    check("last_at_max_cnt", out_cnt, 256);
    check("last_at_max_data", out_data, 512);
    send(32'd5, 1'b1, st);
    check("last_at_max_next_cnt", out_cnt, 1);
    tick(x);

    // Reset mid-frame discards the partial sum; reset beats a simultaneous transfer.
    send(32'd5, 1'b0, st);
    send(32'd6, 1'b0, st);
    rst        = 1'b1;
    prod_valid = 1'b1;
    prod_data  = 32'd77;
    prod_last  = 1'b1;
    tick(x);
    rst        = 1'b0;
    prod_valid = 1'b0;
    check("midrst_valid", out_valid, 0);
    send(32'd9, 1'b1, st);
    check("midrst_data", out_data, 9);
    check("midrst_cnt", out_cnt, 1);
    tick(x);

    // Reset during HOLD drops the unconsumed sum.
    out_ready = 1'b0;
    send(32'd3, 1'b1, st);
    check("hold_pre_valid", out_valid, 1);
    rst = 1'b1;
    tick(x);
    rst = 1'b0;
    check("holdrst_valid", out_valid, 0);
    check("holdrst_data", out_data, 0);

    // Randomized traffic against the frame model.
    for (int i = 0; i < 4000; i++) begin
      rst        = ($urandom_range(0, 299) == 0);
      prod_valid = ($urandom_range(0, 3) != 0);
      prod_data  = ($urandom_range(0, 1) != 0) ? $urandom : $urandom_range(0, 255);
      prod_last  = ($urandom_range(0, 9) == 0);
      out_ready  = ($urandom_range(0, 2) != 0);
      tick(x);
    end
    rst        = 1'b0;
    prod_valid = 1'b0;
    out_ready  = 1'b1;
    tick(x);
    tick(x);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
